ps2_device: RTL and testbench

- Device-side (keyboard/mouse end) PS/2 port engine; the counterpart of the host-side `ps2_transmitter`.
- Generates the PS/2 clock, sends device-to-host frames from a byte stream, detects host inhibit and request-to-send, receives host-to-device command frames and acknowledges them.
- Drives the bus through open-drain enables only (oe=1 pulls the line low).
- Used for loopback verification of the host transceiver and for on-board device emulation.

---
 rtl/ps2_pkg.sv | 22 ++
 rtl/ps2_sync.sv | 37 +++
 rtl/ps2_device.sv | 230 +++++++++++++++++++++++
 tb/tb_ps2_device.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: device FSM encoding, frame layout constants and
// the odd-parity helper used by both the device engine and host transceiver.
package ps2_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_TX      = 3'd1,
      ST_INHIBIT = 3'd2,
      ST_RX      = 3'd3,
      ST_ACK     = 3'd4
   } ps2_state_e;

   localparam int   FRAME_BITS = 11;
   localparam int   RX_CLOCKS  = 10;
   localparam logic START      = 1'b0;
   localparam logic STOP       = 1'b1;

   function automatic logic odd_parity(input logic [7:0] data);
      return ~^data;
   endfunction

endpackage

// File: rtl/ps2_sync.sv
// Two-flop synchronizer for one PS/2 line plus a saturating count of how many
// cycles the synchronized level has been stable (0 on the first cycle).
module ps2_sync #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             async_i,
   output logic             level_o,
   output logic [CNT_W-1:0] stable_o
);

   logic             s1_q;
   logic             s2_q;
   logic [CNT_W-1:0] cnt_q;

   // Flops reset to 1 so a released (pulled-up) bus looks idle straight away.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         s1_q  <= 1'b1;
         s2_q  <= 1'b1;
         cnt_q <= '0;
      end else begin
         s1_q <= async_i;
         s2_q <= s1_q;
         if (s1_q != s2_q) begin
            cnt_q <= '0;
         end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign level_o  = s2_q;
   assign stable_o = cnt_q;

endmodule

// File: rtl/ps2_device.sv
// Device-side PS/2 engine: generates the PS/2 clock, sends bytes to the host,
// detects inhibit / request-to-send, receives and acknowledges host commands.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | bus released; watch for inhibit or start a pending TX
//   ST_TX      | 11 slots (start, data0-7, parity, stop), high then low
//   ST_INHIBIT | host holds clock low; wait for release (RTS if data low)
//   ST_RX      | 10 clock pulses, sample data mid high phase
//   ST_ACK     | one slot: data low in high phase, clock low in low phase
module ps2_device
   import ps2_pkg::*;
#(
   parameter int HALF_PERIOD = 4000,
   parameter int INHIBIT_MIN = 5000,
   parameter int IDLE_MIN    = 5000
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_done,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_parity_err,
   output logic       rx_frame_err,
   output logic       busy
);

   localparam logic [15:0] HP_LAST  = 16'(HALF_PERIOD - 1);
   localparam logic [15:0] HP_MID   = 16'(HALF_PERIOD / 2);
   localparam logic [15:0] INH_CNT  = 16'(INHIBIT_MIN - 1);
   localparam logic [15:0] IDLE_CNT = 16'(IDLE_MIN - 1);
   localparam logic [3:0]  TX_LAST  = 4'(FRAME_BITS - 1);
   localparam logic [3:0]  RX_LAST  = 4'(RX_CLOCKS - 1);

   logic        clk_s, dat_s;
   logic [15:0] clk_cnt, dat_cnt;

   ps2_sync #(.CNT_W(16)) u_sync_clk (
      .clk      (clk),
      .rstn     (rstn),
      .async_i  (ps2_clk_in),
      .level_o  (clk_s),
      .stable_o (clk_cnt)
   );

   ps2_sync #(.CNT_W(16)) u_sync_dat (
      .clk      (clk),
      .rstn     (rstn),
      .async_i  (ps2_data_in),
      .level_o  (dat_s),
      .stable_o (dat_cnt)
   );

   ps2_state_e state_q, state_d;
   logic [15:0] phase_q, phase_d;
   logic [3:0]  bit_q, bit_d;
   logic        half_q, half_d;
   logic        pend_q, pend_d;
   logic [7:0]  pend_data_q, pend_data_d;
   logic [9:0]  rx_shift_q, rx_shift_d;
   logic [7:0]  rx_data_q, rx_data_d;
   logic        rx_perr_q, rx_perr_d;
   logic        rx_valid_q, rx_valid_d;
   logic        rx_ferr_q, rx_ferr_d;
   logic        tx_done_q, tx_done_d;
   logic        clk_oe_q, clk_oe_d;
   logic        data_oe_q, data_oe_d;
   logic        phase_last;
   logic [FRAME_BITS-1:0] tx_frame;

   assign tx_frame   = {STOP, odd_parity(pend_data_q), pend_data_q, START};
   assign phase_last = (phase_q == HP_LAST);
   assign tx_ready   = (state_q == ST_IDLE) && !pend_q;

   always_comb begin
      state_d     = state_q;
      phase_d     = phase_last ? '0 : phase_q + 16'd1;
      bit_d       = bit_q;
      half_d      = half_q;
      pend_d      = pend_q;
      pend_data_d = pend_data_q;
      rx_shift_d  = rx_shift_q;
      rx_data_d   = rx_data_q;
      rx_perr_d   = rx_perr_q;
      rx_valid_d  = 1'b0;
      rx_ferr_d   = 1'b0;
      tx_done_d   = 1'b0;

      if (tx_ready && tx_valid) begin
         pend_d      = 1'b1;
         pend_data_d = tx_data;
      end

      unique case (state_q)
         ST_IDLE: begin
            phase_d = '0;
            bit_d   = '0;
            half_d  = 1'b0;
            if (!clk_s && clk_cnt >= INH_CNT) begin
               state_d = ST_INHIBIT;
            end else if (pend_q && clk_s && dat_s &&
                         clk_cnt >= IDLE_CNT && dat_cnt >= IDLE_CNT) begin
               state_d = ST_TX;
            end
         end
         ST_TX: begin
            if (phase_last) begin
               if (!half_q) begin
                  // Clock low at the end of our high phase: host took the bus.
                  if (bit_q != TX_LAST && !clk_s) begin
                     state_d = ST_INHIBIT;
                  end else begin
                     half_d = 1'b1;
                  end
               end else begin
                  half_d = 1'b0;
                  if (bit_q == TX_LAST) begin
                     tx_done_d = 1'b1;
                     pend_d    = 1'b0;
                     state_d   = ST_IDLE;
                  end else begin
                     bit_d = bit_q + 4'd1;
                  end
               end
            end
         end
         ST_INHIBIT: begin
            phase_d = '0;
            bit_d   = '0;
            half_d  = 1'b0;
            if (clk_s) begin
               state_d = dat_s ? ST_IDLE : ST_RX;
            end
         end
         ST_RX: begin
            if (!half_q && phase_q == HP_MID) begin
               rx_shift_d = {dat_s, rx_shift_q[9:1]};
            end
            if (phase_last) begin
               if (!half_q) begin
                  half_d = 1'b1;
               end else begin
                  half_d = 1'b0;
                  if (bit_q == RX_LAST) begin
                     bit_d = '0;
                     if (rx_shift_q[9] == STOP) begin
                        state_d = ST_ACK;
                     end else begin
                        rx_ferr_d = 1'b1;
                        state_d   = ST_IDLE;
                     end
                  end else begin
                     bit_d = bit_q + 4'd1;
                  end
               end
            end
         end
         ST_ACK: begin
            if (phase_last) begin
               if (!half_q) begin
                  half_d = 1'b1;
               end else begin
                  half_d     = 1'b0;
                  state_d    = ST_IDLE;
                  rx_data_d  = rx_shift_q[7:0];
                  rx_perr_d  = (rx_shift_q[8] != odd_parity(rx_shift_q[7:0]));
                  rx_valid_d = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Line enables follow the next state so they are registered yet never lag.
      clk_oe_d  = (state_d == ST_TX || state_d == ST_RX || state_d == ST_ACK) && half_d;
      data_oe_d = ((state_d == ST_TX) && !tx_frame[bit_d]) ||
                  ((state_d == ST_ACK) && !half_d);
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q     <= ST_IDLE;
         phase_q     <= '0;
         bit_q       <= '0;
         half_q      <= 1'b0;
         pend_q      <= 1'b0;
         pend_data_q <= '0;
         rx_shift_q  <= '0;
         rx_data_q   <= '0;
         rx_perr_q   <= 1'b0;
         rx_valid_q  <= 1'b0;
         rx_ferr_q   <= 1'b0;
         tx_done_q   <= 1'b0;
         clk_oe_q    <= 1'b0;
         data_oe_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         bit_q       <= bit_d;
         half_q      <= half_d;
         pend_q      <= pend_d;
         pend_data_q <= pend_data_d;
         rx_shift_q  <= rx_shift_d;
         rx_data_q   <= rx_data_d;
         rx_perr_q   <= rx_perr_d;
         rx_valid_q  <= rx_valid_d;
         rx_ferr_q   <= rx_ferr_d;
         tx_done_q   <= tx_done_d;
         clk_oe_q    <= clk_oe_d;
         data_oe_q   <= data_oe_d;
      end
   end

   assign ps2_clk_oe    = clk_oe_q;
   assign ps2_data_oe   = data_oe_q;
   assign tx_done       = tx_done_q;
   assign rx_data       = rx_data_q;
   assign rx_valid      = rx_valid_q;
   assign rx_parity_err = rx_perr_q;
   assign rx_frame_err  = rx_ferr_q;
   assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ps2_device.sv
// Bench for ps2_device: open-drain bus model with a scripted host, table-driven
// TX/RX frames plus hand-written collision and mid-frame reset sequences.
module tb_ps2_device;

   localparam int HP = 8;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       host_clk = 1'b1;
   logic       host_data = 1'b1;
   logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready, tx_done, rx_valid, rx_parity_err, rx_frame_err, busy;
   logic [7:0] rx_data;

   assign ps2_clk_in  = ~ps2_clk_oe & host_clk;
   assign ps2_data_in = ~ps2_data_oe & host_data;

   always #5 clk = ~clk;

   ps2_device #(.HALF_PERIOD(HP), .INHIBIT_MIN(10), .IDLE_MIN(10)) dut (
      .clk           (clk),
      .rstn          (rstn),
      .ps2_clk_in    (ps2_clk_in),
      .ps2_data_in   (ps2_data_in),
      .ps2_clk_oe    (ps2_clk_oe),
      .ps2_data_oe   (ps2_data_oe),
      .tx_data       (tx_data),
      .tx_valid      (tx_valid),
      .tx_ready      (tx_ready),
      .tx_done       (tx_done),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .rx_parity_err (rx_parity_err),
      .rx_frame_err  (rx_frame_err),
      .busy          (busy)
   );

   // Host-side observer: samples data on clock-line falling edges, counts pulses.
   logic       mon_bits [0:511];
   int         mon_cnt = 0;
   int         n_done = 0, n_valid = 0, n_ferr = 0, n_ack = 0;
   logic [7:0] last_rx_data = 8'h00;
   logic       last_perr = 1'b0;
   logic       line_clk_prev = 1'b1;

   always @(negedge clk) begin
      line_clk_prev <= ps2_clk_in;
      if (line_clk_prev && !ps2_clk_in) begin
         mon_bits[mon_cnt % 512] <= ps2_data_in;
         mon_cnt <= mon_cnt + 1;
      end
      if (tx_done) n_done <= n_done + 1;
      if (rx_frame_err) n_ferr <= n_ferr + 1;
      if (ps2_data_oe) n_ack <= n_ack + 1;
      if (rx_valid) begin
         n_valid      <= n_valid + 1;
         last_rx_data <= rx_data;
         last_perr    <= rx_parity_err;
      end
   end

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Wait for a clk_oe edge (rise=1 for rising), bounded; failure is counted.
   task automatic wait_oe(input bit rise, input string name);
      logic prev;
      bit   ok;
      prev = ps2_clk_oe;
      ok   = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (ps2_clk_oe == rise && prev == !rise) begin
            ok = 1'b1;
            break;
         end
         prev = ps2_clk_oe;
      end
      if (!ok) check({name, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic wait_done(input int d0);
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (n_done != d0) break;
      end
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (!busy) break;
      end
   endtask

   function automatic logic [10:0] grab_frame(input int base);
      logic [10:0] f;
      for (int i = 0; i < 11; i++) f[i] = mon_bits[(base + i) % 512];
      return f;
   endfunction

   // Host sends RTS then clocks out {stop, parity, data} under the device clock.
   task automatic host_rx_frame(input logic [9:0] bits);
      host_clk  = 1'b0;
      host_data = 1'b0;
      cyc(12);
      host_clk = 1'b1;
      cyc(3);
      host_data = bits[0];
      for (int k = 1; k < 10; k++) begin
         wait_oe(1'b1, "rx_pulse");
         host_data = bits[k];
      end
      wait_oe(1'b1, "rx_last_pulse");
      host_data = 1'b1;
      wait_idle();
      cyc(4);
   endtask

   typedef struct {
      logic [7:0]  data;
      logic [10:0] frame;
   } tx_vec_t;

   typedef struct {
      logic [7:0] data;
      logic       par;
      logic       stop;
      logic       exp_valid;
      logic       exp_perr;
      logic       exp_ferr;
      int         exp_ack;
   } rx_vec_t;

   tx_vec_t tx_tab [4];
   rx_vec_t rx_tab [5];

   initial begin
      int base, d0, v0, f0, a0;

      // frame = {stop, parity, data, start}, bit 0 is the start bit
      tx_tab[0] = '{8'h5A, 11'h6B4};
      tx_tab[1] = '{8'h00, 11'h600};
      tx_tab[2] = '{8'h01, 11'h402};
      tx_tab[3] = '{8'hFF, 11'h7FE};

      rx_tab[0] = '{8'hF4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, HP};
      rx_tab[1] = '{8'hF4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, HP};
      rx_tab[2] = '{8'hF4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0};
      rx_tab[3] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, HP};
      rx_tab[4] = '{8'hAA, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, HP};

      cyc(4);
      check("rst_clk_oe",   {31'd0, ps2_clk_oe},   32'd0);
      check("rst_data_oe",  {31'd0, ps2_data_oe},  32'd0);
      check("rst_busy",     {31'd0, busy},         32'd0);
      check("rst_tx_done",  {31'd0, tx_done},      32'd0);
      check("rst_rx_valid", {31'd0, rx_valid},     32'd0);
      check("rst_rx_data",  {24'd0, rx_data},      32'd0);
      check("rst_tx_ready", {31'd0, tx_ready},     32'd1);
      rstn = 1'b1;
      cyc(5);

      foreach (tx_tab[t]) begin
         base = mon_cnt;
         d0   = n_done;
         check("tx_ready_before", {31'd0, tx_ready}, 32'd1);
         tx_data  = tx_tab[t].data;
         tx_valid = 1'b1;
         @(negedge clk);
         tx_valid = 1'b0;
         check("tx_ready_pending", {31'd0, tx_ready}, 32'd0);
         wait_done(d0);
         cyc(3);
         check("tx_frame",      {21'd0, grab_frame(base)}, {21'd0, tx_tab[t].frame});
         check("tx_edge_count", mon_cnt - base, 32'd11);
         check("tx_done_once",  n_done - d0, 32'd1);
         check("tx_ready_after", {31'd0, tx_ready}, 32'd1);
         check("tx_busy_after",  {31'd0, busy}, 32'd0);
         cyc(5);
      end

      foreach (rx_tab[r]) begin
         v0 = n_valid;
         f0 = n_ferr;
         a0 = n_ack;
         host_rx_frame({rx_tab[r].stop, rx_tab[r].par, rx_tab[r].data});
         check("rx_valid_count", n_valid - v0, {31'd0, rx_tab[r].exp_valid});
         check("rx_ferr_count",  n_ferr - f0,  {31'd0, rx_tab[r].exp_ferr});
         check("rx_ack_cycles",  n_ack - a0,   rx_tab[r].exp_ack);
         if (rx_tab[r].exp_valid) begin
            check("rx_data", {24'd0, last_rx_data}, {24'd0, rx_tab[r].data});
            check("rx_perr", {31'd0, last_perr},    {31'd0, rx_tab[r].exp_perr});
         end
         cyc(5);
      end

      // Collision: host grabs the clock during slot 4 high phase of 0xFA.
      base = mon_cnt;
      d0   = n_done;
      tx_data  = 8'hFA;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         if (mon_cnt - base >= 4) break;
         @(negedge clk);
      end
      check("col_slot3_reached", mon_cnt - base, 32'd4);
      wait_oe(1'b0, "col_slot4_high");
      host_clk = 1'b0;
      cyc(12);
      check("col_busy",    {31'd0, busy},        32'd1);
      check("col_clk_oe",  {31'd0, ps2_clk_oe},  32'd0);
      check("col_data_oe", {31'd0, ps2_data_oe}, 32'd0);
      check("col_no_done", n_done - d0,          32'd0);
      check("col_pending", {31'd0, tx_ready},    32'd0);
      cyc(8);
      base = mon_cnt;
      host_clk = 1'b1;
      wait_done(d0);
      cyc(3);
      check("col_resend_frame", {21'd0, grab_frame(base)}, {21'd0, 11'h7F4});
      check("col_resend_edges", mon_cnt - base, 32'd11);
      check("col_done_once",    n_done - d0,    32'd1);
      cyc(5);

      // Reset during RX pulse 5.
      v0 = n_valid;
      host_clk  = 1'b0;
      host_data = 1'b0;
      cyc(12);
      host_clk = 1'b1;
      cyc(3);
      host_data = 1'b1;
      for (int k = 0; k < 5; k++) wait_oe(1'b1, "rst_rx_pulse");
      wait_oe(1'b0, "rst_rx_slot5");
      rstn = 1'b0;
      @(posedge clk);
      #1;
      check("rstrx_clk_oe",   {31'd0, ps2_clk_oe},  32'd0);
      check("rstrx_data_oe",  {31'd0, ps2_data_oe}, 32'd0);
      check("rstrx_busy",     {31'd0, busy},        32'd0);
      check("rstrx_tx_ready", {31'd0, tx_ready},    32'd1);
      check("rstrx_rx_valid", {31'd0, rx_valid},    32'd0);
      @(negedge clk);
      rstn = 1'b1;
      cyc(40);
      check("rstrx_no_valid", n_valid - v0,  32'd0);
      check("rstrx_idle",     {31'd0, busy}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
